// File: rtl/lru_resolve_pkg.sv
// Shared types for the LRU resolve stage: tagged key beats, values and write-path results.
// Optional build macro: LRU_RESOLVE_STATS_EN adds hit/miss beat counters on the top level.
package lru_resolve_pkg;

    localparam int KEY_BITS          = 16;
    localparam int DATA_BITS         = 64;
    localparam int DEF_CACHE_DEPTH   = 8;

    typedef logic [KEY_BITS-1:0]  agg_key_t;
    typedef logic [DATA_BITS-1:0] agg_val_t;

    // Tagged key from the hit-tagging stage.
    typedef struct packed {
        agg_key_t key;
        logic     last;
        logic     hit;
    } dist_t;

    // Result beat toward the memory write path.
    typedef struct packed {
        agg_key_t key;
        agg_val_t value;
        logic     last;
    } agg_wr_t;

endpackage

// File: rtl/lru_fwd_window.sv
// Forward window: shift register of recent {key,value} results with a youngest-first lookup.
// Entry 0 is the youngest; a result written this cycle is visible to the lookup next cycle.
module lru_fwd_window
    import lru_resolve_pkg::*;
#(
    parameter int DEPTH = DEF_CACHE_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     shift_en,
    input  agg_key_t new_key,
    input  agg_val_t new_value,
    input  agg_key_t lookup_key,
    output logic     match,
    output agg_val_t value
);

    logic [DEPTH-1:0][KEY_BITS-1:0]  keys;
    logic [DEPTH-1:0][DATA_BITS-1:0] vals;
    logic [DEPTH-1:0]                vld;

    // Shift the new result into entry 0, dropping the oldest entry; only valid bits need reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (shift_en) begin
            keys <= {keys[DEPTH-2:0], new_key};
            vals <= {vals[DEPTH-2:0], new_value};
            vld  <= {vld[DEPTH-2:0], 1'b1};
        end
    end

    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        match = 1'b0;
        value = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && keys[i] == lookup_key) begin
                match = 1'b1;
                value = vals[i];
            end
        end
    end

endmodule

// File: rtl/lru_resolve.sv
// LRU resolve stage: joins tagged keys, operands and memory read data, adds base+operand,
// forwards bases for hits from a window of recent results, and drives the write path.
// Optional build macro: LRU_RESOLVE_STATS_EN adds hit_cnt / miss_cnt outputs.
module lru_resolve
    import lru_resolve_pkg::*;
#(
    parameter int CACHE_DEPTH = DEF_CACHE_DEPTH
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_meta_valid,
    output logic        s_meta_ready,
    input  dist_t       s_meta_data,
    input  logic        s_op_valid,
    output logic        s_op_ready,
    input  agg_val_t    s_op_data,
    input  logic        s_rd_valid,
    output logic        s_rd_ready,
    input  agg_val_t    s_rd_data,
    output logic        m_wr_valid,
    input  logic        m_wr_ready,
    output agg_wr_t     m_wr_data,
`ifdef LRU_RESOLVE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic        err
);

    logic     fire;
    logic     win_match;
    agg_val_t win_value;
    agg_val_t base;
    agg_val_t sum;

    // A beat fires only when every source it needs is present and the output slot is free;
    // aresetn gates it so readies stay low throughout reset.
    assign fire = aresetn & s_meta_valid & s_op_valid
                & (s_meta_data.hit | s_rd_valid)
                & (~m_wr_valid | m_wr_ready);

    assign s_meta_ready = fire;
    assign s_op_ready   = fire;
    assign s_rd_ready   = fire & ~s_meta_data.hit;

    lru_fwd_window #(.DEPTH(CACHE_DEPTH)) u_window (
        .clk        (aclk),
        .rst_n      (aresetn),
        .shift_en   (fire),
        .new_key    (s_meta_data.key),
        .new_value  (sum),
        .lookup_key (s_meta_data.key),
        .match      (win_match),
        .value      (win_value)
    );

    // Hits take the forwarded value (zero when orphaned); misses always take read data.
    always_comb begin
        base = s_rd_data;
        if (s_meta_data.hit) begin
            base = win_match ? win_value : '0;
        end
    end

    assign sum = base + s_op_data;

    // Output register: loads on fire, clears after acceptance, holds while stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_wr_valid <= 1'b0;
            m_wr_data  <= '0;
        end else if (fire) begin
            m_wr_valid      <= 1'b1;
            m_wr_data.key   <= s_meta_data.key;
            m_wr_data.value <= sum;
            m_wr_data.last  <= s_meta_data.last;
        end else if (m_wr_ready) begin
            m_wr_valid <= 1'b0;
        end
    end

    // Sticky error: a tagged hit whose producer is not in the window.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err <= 1'b0;
        end else if (fire && s_meta_data.hit && !win_match) begin
            err <= 1'b1;
        end
    end

`ifdef LRU_RESOLVE_STATS_EN
    // Fired-beat counters split by hit tag; wrap naturally at 2^32.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (fire) begin
            if (s_meta_data.hit) hit_cnt  <= hit_cnt + 32'd1;
            else                 miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lru_resolve.sv
// Self-checking bench for lru_resolve: table-driven directed groups, hand-written
// backpressure sequence, and randomized traffic against a queue-based window model.
module tb_lru_resolve;
    import lru_resolve_pkg::*;

    logic     aclk = 1'b0;
    logic     aresetn;
    logic     s_meta_valid, s_meta_ready;
    dist_t    s_meta_data;
    logic     s_op_valid, s_op_ready;
    agg_val_t s_op_data;
    logic     s_rd_valid, s_rd_ready;
    agg_val_t s_rd_data;
    logic     m_wr_valid, m_wr_ready;
    agg_wr_t  m_wr_data;
    logic     err;
`ifdef LRU_RESOLVE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    lru_resolve #(.CACHE_DEPTH(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_meta_valid (s_meta_valid),
        .s_meta_ready (s_meta_ready),
        .s_meta_data  (s_meta_data),
        .s_op_valid   (s_op_valid),
        .s_op_ready   (s_op_ready),
        .s_op_data    (s_op_data),
        .s_rd_valid   (s_rd_valid),
        .s_rd_ready   (s_rd_ready),
        .s_rd_data    (s_rd_data),
        .m_wr_valid   (m_wr_valid),
        .m_wr_ready   (m_wr_ready),
        .m_wr_data    (m_wr_data),
`ifdef LRU_RESOLVE_STATS_EN
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
`endif
        .err          (err)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    // ---------------- source/sink harness ----------------
    dist_t    q_meta[$];
    agg_val_t q_op[$];
    agg_val_t q_rd[$];
    agg_wr_t  q_exp[$];
    int       out_cyc[$];
    int       cyc = 0;
    int       rd_pops, exp_rd_pops;
    int       rdy_mode;   // 0: always ready, 1: random, 2: never
    bit       gaps;       // random valid drops on sources
    bit       held;
    agg_wr_t  held_data;
    logic     last_meta_rdy, last_op_rdy, last_rd_rdy;

    // ---------------- reference model ----------------
    typedef struct { agg_key_t key; agg_val_t val; } went_t;
    went_t mwin[$];   // index 0 = most recent result
    bit    m_err;

    function automatic agg_val_t model_beat(input agg_key_t key, input logic hit,
                                            input agg_val_t op, input agg_val_t rd);
        agg_val_t b;
        bit found;
        went_t e;
        b = rd;
        if (hit) begin
            found = 0;
            b = '0;
            foreach (mwin[i]) begin
                if (!found && mwin[i].key == key) begin
                    found = 1;
                    b = mwin[i].val;
                end
            end
            if (!found) m_err = 1;
        end
        e.key = key;
        e.val = b + op;
        mwin.push_front(e);
        if (mwin.size() > 8) void'(mwin.pop_back());
        return e.val;
    endfunction

    task automatic add_beat(input agg_key_t key, input logic hit, input logic last,
                            input agg_val_t op, input agg_val_t rd,
                            input bit use_exp, input agg_val_t exp_v);
        dist_t m;
        agg_wr_t w;
        agg_val_t mv;
        m.key = key; m.hit = hit; m.last = last;
        q_meta.push_back(m);
        q_op.push_back(op);
        if (!hit) begin
            q_rd.push_back(rd);
            exp_rd_pops++;
        end
        mv = model_beat(key, hit, op, rd);
        w.key = key; w.last = last;
        w.value = use_exp ? exp_v : mv;
        q_exp.push_back(w);
    endtask

    task automatic cycle();
        bit tm, to, tr;
        agg_wr_t e;
        @(negedge aclk);
        s_meta_valid = (q_meta.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        s_op_valid   = (q_op.size()   > 0) && (!gaps || $urandom_range(0, 3) != 0);
        s_rd_valid   = (q_rd.size()   > 0) && (!gaps || $urandom_range(0, 3) != 0);
        if (q_meta.size() > 0) s_meta_data = q_meta[0];
        if (q_op.size()   > 0) s_op_data   = q_op[0];
        if (q_rd.size()   > 0) s_rd_data   = q_rd[0];
        case (rdy_mode)
            0:       m_wr_ready = 1'b1;
            1:       m_wr_ready = 1'($urandom_range(0, 1));
            default: m_wr_ready = 1'b0;
        endcase
        #1;
        if (held) chk(m_wr_valid && m_wr_data == held_data, "hold_stable", m_wr_data.value, held_data.value);
        if (m_wr_valid && m_wr_ready) begin
            if (q_exp.size() == 0) chk(0, "extra_output", m_wr_data.value, 0);
            else begin
                e = q_exp.pop_front();
                chk(m_wr_data == e, "out_beat", {m_wr_data.key, m_wr_data.value[47:0]}, {e.key, e.value[47:0]});
                out_cyc.push_back(cyc);
            end
        end
        held      = m_wr_valid && !m_wr_ready;
        held_data = m_wr_data;
        if (s_meta_ready || s_op_ready || s_rd_ready)
            chk(s_meta_ready == s_op_ready && s_rd_ready == (s_meta_ready && !s_meta_data.hit),
                "ready_join", {s_meta_ready, s_op_ready, s_rd_ready}, {1'b1, 1'b1, !s_meta_data.hit});
        last_meta_rdy = s_meta_ready; last_op_rdy = s_op_ready; last_rd_rdy = s_rd_ready;
        tm = s_meta_valid && s_meta_ready;
        to = s_op_valid && s_op_ready;
        tr = s_rd_valid && s_rd_ready;
        @(posedge aclk);
        cyc++;
        if (tm) void'(q_meta.pop_front());
        if (to) void'(q_op.pop_front());
        if (tr) begin
            void'(q_rd.pop_front());
            rd_pops++;
        end
    endtask

    task automatic run_drain(input int max);
        int n = 0;
        while ((q_meta.size() > 0 || q_op.size() > 0 || q_exp.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        if (q_meta.size() > 0 || q_op.size() > 0 || q_exp.size() > 0)
            chk(0, "drain_timeout", q_exp.size(), 0);
    endtask

    task automatic settle();
        @(negedge aclk);
        s_meta_valid = 0; s_op_valid = 0; s_rd_valid = 0;
        #1;
    endtask

    task automatic do_reset();
        q_meta.delete(); q_op.delete(); q_rd.delete(); q_exp.delete(); out_cyc.delete();
        mwin.delete(); m_err = 0; held = 0;
        rd_pops = 0; exp_rd_pops = 0; rdy_mode = 0; gaps = 0;
        @(negedge aclk);
        aresetn = 0;
        s_meta_valid = 1; s_op_valid = 1; s_rd_valid = 1; m_wr_ready = 1;
        s_meta_data = '0; s_op_data = 64'd1; s_rd_data = 64'd2;
        repeat (2) @(negedge aclk);
        #1;
        chk({s_meta_ready, s_op_ready, s_rd_ready} == 3'b000, "rst_readies",
            {s_meta_ready, s_op_ready, s_rd_ready}, 0);
        chk(!m_wr_valid && m_wr_data == '0 && !err, "rst_state",
            {m_wr_valid, err, m_wr_data.value[31:0]}, 0);
        @(negedge aclk);
        s_meta_valid = 0; s_op_valid = 0; s_rd_valid = 0;
        aresetn = 1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int       grp;
        agg_key_t key;
        logic     hit;
        logic     last;
        agg_val_t op;
        agg_val_t rd;
        agg_val_t exp_v;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input int g, input agg_key_t k, input logic h, input logic l,
                        input agg_val_t op, input agg_val_t rd, input agg_val_t ev);
        vec_t v;
        v.grp = g; v.key = k; v.hit = h; v.last = l; v.op = op; v.rd = rd; v.exp_v = ev;
        vecs.push_back(v);
    endtask

    initial begin
        int groups[6];
        int exp_rd_tbl;
        aresetn = 0;
        s_meta_valid = 0; s_op_valid = 0; s_rd_valid = 0; m_wr_ready = 1;
        s_meta_data = '0; s_op_data = '0; s_rd_data = '0;

        // group 1: single miss
        addv(1, 5, 0, 0, 3, 10, 13);
        // group 2: miss then hit on same key
        addv(2, 7, 0, 0, 2, 1, 3);
        addv(2, 7, 1, 1, 4, 0, 7);
        // group 3: back-to-back same key
        addv(3, 9, 0, 0, 1, 0, 1);
        addv(3, 9, 1, 0, 1, 0, 2);
        addv(3, 9, 1, 1, 1, 0, 3);
        // group 5: orphan hit, then an ordinary miss (err must stay set)
        addv(5, 42, 1, 0, 6, 0, 6);
        addv(5, 3, 0, 1, 1, 1, 2);
        // group 6: eviction of key 1 after 9 distinct misses
        for (int k = 1; k <= 9; k++) addv(6, agg_key_t'(k), 0, 0, 1, agg_val_t'(k * 10), agg_val_t'(k * 10 + 1));
        addv(6, 1, 1, 1, 5, 0, 5);
        // group 7: wraparound and miss-with-key-in-window uses read data
        addv(7, 20, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1);
        addv(7, 20, 0, 1, 5, 100, 105);

        groups = '{1, 2, 3, 5, 6, 7};
        foreach (groups[gi]) begin
            do_reset();
            exp_rd_tbl = 0;
            foreach (vecs[i]) begin
                if (vecs[i].grp == groups[gi]) begin
                    add_beat(vecs[i].key, vecs[i].hit, vecs[i].last, vecs[i].op, vecs[i].rd, 1, vecs[i].exp_v);
                    if (!vecs[i].hit) exp_rd_tbl++;
                end
            end
            run_drain(200);
            settle();
            chk(rd_pops == exp_rd_tbl, "rd_pops", rd_pops, exp_rd_tbl);
            chk(err == (groups[gi] == 5 || groups[gi] == 6), "err_grp", err, (groups[gi] == 5 || groups[gi] == 6));
            if (groups[gi] == 3) begin
                chk(out_cyc.size() == 3 && out_cyc[1] - out_cyc[0] == 1 && out_cyc[2] - out_cyc[1] == 1,
                    "no_bubble", out_cyc.size() == 3 ? out_cyc[2] - out_cyc[0] : 99, 2);
            end
`ifdef LRU_RESOLVE_STATS_EN
            if (groups[gi] == 6) begin
                chk(miss_cnt == 32'd9, "miss_cnt", miss_cnt, 9);
                chk(hit_cnt == 32'd1, "hit_cnt", hit_cnt, 1);
            end
`endif
        end

        // backpressure: first beat fires, then output stalls for 5 cycles
        do_reset();
        add_beat(11, 0, 0, 1, 4, 1, 5);
        add_beat(12, 0, 1, 2, 6, 1, 8);
        rdy_mode = 2;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk({last_meta_rdy, last_op_rdy, last_rd_rdy} == 3'b000 && q_meta.size() == 1 && rd_pops == 1,
                "bp_no_pop", {last_meta_rdy, last_op_rdy, last_rd_rdy, 5'(q_meta.size())}, 1);
        end
        rdy_mode = 0;
        run_drain(50);
        settle();
        chk(rd_pops == 2, "bp_rd_pops", rd_pops, 2);

        // randomized traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rdy_mode = 1;
            gaps = 1;
            for (int i = 0; i < 150; i++) begin
                agg_val_t op;
                agg_val_t rd;
                op = {$urandom, $urandom};
                rd = {$urandom, $urandom};
                add_beat(agg_key_t'($urandom_range(0, 11)), 1'($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 9) == 0), op, rd, 0, '0);
            end
            run_drain(5000);
            settle();
            chk(err == m_err, "rand_err", err, m_err);
            chk(rd_pops == exp_rd_pops, "rand_rd_pops", rd_pops, exp_rd_pops);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
